lift53_seq: RTL and testbench

Sequencer for the LeGall 5/3 lifting datapath (`jpeg` unit: `l_s`/`r_s`/`s_s` in, `e_o_s`/`f_i_s` select, one-cycle registered `res_s`). It runs a complete in-place 1-D forward or inverse lifting transform over one row held in a sample RAM. For each target sample it fetches the target and both neighbours, applies symmetric boundary extension, drives the datapath, and writes the result back. It sits between the row-buffer RAM and the datapath and is started by the 2-D tile controller once per row or column.

---
 rtl/lift53_seq_if.sv | 41 ++++
 rtl/lift53_seq.sv | 174 +++++++++++++++++
 tb/tb_lift53_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift53_seq_if.sv
// Bundle between the 5/3 lifting sequencer, its row-buffer RAM, the datapath
// and the tile controller. The sequencer uses the slave side; the
// environment (controller, RAM, datapath) uses the master side.
`timescale 1ns/1ps
interface lift53_seq_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  // command / status
  logic          start;
  logic          fwd;
  logic [AW:0]   len;
  logic [AW-1:0] base;
  logic          busy;
  logic          done;
  // sample RAM
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  // lifting datapath
  logic [DW-1:0] l_s;
  logic [DW-1:0] r_s;
  logic [DW-1:0] s_s;
  logic          e_o_s;
  logic          f_i_s;
  logic [DW-1:0] res_s;

  modport master (
    output start, fwd, len, base, mem_rdata, res_s,
    input  busy, done, mem_raddr, mem_we, mem_waddr, mem_wdata,
           l_s, r_s, s_s, e_o_s, f_i_s
  );

  modport slave (
    input  start, fwd, len, base, mem_rdata, res_s,
    output busy, done, mem_raddr, mem_we, mem_waddr, mem_wdata,
           l_s, r_s, s_s, e_o_s, f_i_s
  );
endinterface

// File: rtl/lift53_seq.sv
// In-place 1-D LeGall 5/3 lifting sequencer. Walks one row in two passes
// (odd then even for forward, even then odd for inverse), fetching each
// target and its two symmetrically-extended neighbours, handing them to the
// datapath and writing the result back. Six cycles per sample.
`timescale 1ns/1ps
module lift53_seq #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input logic         clk,
  input logic         rst,
  lift53_seq_if.slave bus
);
  // index width has headroom for idx+2 past a full-length row
  localparam int IW = AW + 2;
  localparam logic [IW-1:0] ONE   = IW'(1);
  localparam logic [IW-1:0] TWO   = IW'(2);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [AW-1:0] TWO_A = AW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_RL, S_RS, S_RR, S_EX, S_CALC, S_WB, S_DONE
  } state_t;

  state_t        state_reg;
  logic          fwd_reg;
  logic          pass_reg;
  logic [IW-1:0] len_reg;
  logic [AW-1:0] base_reg;
  logic [IW-1:0] idx_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          we_reg;
  logic [AW-1:0] raddr_reg;
  logic [AW-1:0] waddr_reg;
  logic [DW-1:0] l_reg;
  logic [DW-1:0] s_reg;
  logic [DW-1:0] r_reg;
  logic          eo_reg;
  logic          fi_reg;

  logic [IW-1:0] len_in;
  logic [IW-1:0] step_idx;
  logic [IW-1:0] idx_p1;
  logic          last_in_pass;
  logic [IW-1:0] rl_idx;
  logic [AW-1:0] rl_left;
  logic [AW-1:0] right_a;
  logic [AW-1:0] base_eff;

  assign len_in       = {1'b0, bus.len};
  assign step_idx     = idx_reg + TWO;
  assign idx_p1       = idx_reg + ONE;
  assign last_in_pass = (step_idx >= len_reg);
  // in IDLE the command inputs are not latched yet, so use them directly
  assign base_eff     = (state_reg == S_IDLE) ? bus.base : base_reg;

  // Index of the next target to enter RL: first of pass 0 from IDLE,
  // otherwise the next index in this pass or the first of pass 1.
  always_comb begin
    rl_idx = step_idx;
    if (state_reg == S_IDLE) begin
      rl_idx = bus.fwd ? ONE : '0;
    end else if (last_in_pass) begin
      rl_idx = fwd_reg ? '0 : ONE;
    end
  end

  // Symmetric extension: index -1 reflects to 1, index len reflects to len-2.
  assign rl_left = (rl_idx == '0) ? ONE_A : (rl_idx[AW-1:0] - ONE_A);
  assign right_a = (idx_p1 == len_reg) ? (len_reg[AW-1:0] - TWO_A) : idx_p1[AW-1:0];

  // Sequencer FSM with registered RAM, datapath and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      fwd_reg   <= 1'b0;
      pass_reg  <= 1'b0;
      len_reg   <= '0;
      base_reg  <= '0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      we_reg    <= 1'b0;
      raddr_reg <= '0;
      waddr_reg <= '0;
      l_reg     <= '0;
      s_reg     <= '0;
      r_reg     <= '0;
      eo_reg    <= 1'b0;
      fi_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      we_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            fwd_reg  <= bus.fwd;
            len_reg  <= len_in;
            base_reg <= bus.base;
            fi_reg   <= bus.fwd;
            if (len_in < TWO) begin
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              busy_reg  <= 1'b1;
              pass_reg  <= 1'b0;
              idx_reg   <= rl_idx;
              eo_reg    <= rl_idx[0];
              raddr_reg <= base_eff + rl_left;
              state_reg <= S_RL;
            end
          end
        end
        S_RL: begin
          raddr_reg <= base_reg + idx_reg[AW-1:0];
          state_reg <= S_RS;
        end
        S_RS: begin
          l_reg     <= bus.mem_rdata;
          raddr_reg <= base_reg + right_a;
          state_reg <= S_RR;
        end
        S_RR: begin
          s_reg     <= bus.mem_rdata;
          state_reg <= S_EX;
        end
        S_EX: begin
          r_reg     <= bus.mem_rdata;
          state_reg <= S_CALC;
        end
        S_CALC: begin
          we_reg    <= 1'b1;
          waddr_reg <= base_reg + idx_reg[AW-1:0];
          state_reg <= S_WB;
        end
        S_WB: begin
          if (last_in_pass && pass_reg) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            if (last_in_pass) begin
              pass_reg <= 1'b1;
            end
            idx_reg   <= rl_idx;
            eo_reg    <= rl_idx[0];
            raddr_reg <= base_eff + rl_left;
            state_reg <= S_RL;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.mem_raddr = raddr_reg;
  assign bus.mem_we    = we_reg;
  assign bus.mem_waddr = waddr_reg;
  // datapath result is only valid in WB, so it is passed straight through
  assign bus.mem_wdata = bus.res_s;
  assign bus.l_s       = l_reg;
  assign bus.s_s       = s_reg;
  assign bus.r_s       = r_reg;
  assign bus.e_o_s     = eo_reg;
  assign bus.f_i_s     = fi_reg;
endmodule

// File: tb/tb_lift53_seq.sv
// Bench for lift53_seq: registered-read RAM, a one-cycle lifting datapath,
// and an array-based 5/3 reference model of the whole row transform.
`timescale 1ns/1ps
module tb_lift53_seq;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int RSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst;

  lift53_seq_if #(.AW(AW), .DW(DW)) bus ();
  lift53_seq #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:RSZ-1];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  int            wr_cnt;
  int            busy_cnt;
  logic [AW-1:0] wr_log [0:4095];

  int checks;
  int failures;
  int ref_x [0:RSZ-1];
  int exp_ord [$];
  int d1 [4] = '{10, 20, 30, 40};
  int e1 [4] = '{10, 0, 33, 10};
  int e3 [3] = '{6, -4, 6};

  // RAM: registered read, no bypass; also logs writes and busy cycles
  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (bus.mem_we) begin
      ram[bus.mem_waddr] <= bus.mem_wdata;
      wr_log[wr_cnt % 4096] <= bus.mem_waddr;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.busy) busy_cnt <= busy_cnt + 1;
    bus.mem_rdata <= ram[bus.mem_raddr];
  end

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [DW-1:0] dp_f(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                         input logic [DW-1:0] s, input logic eo, input logic fi);
    int a, v;
    a = sx(l) + sx(r);
    if (eo) v = fi ? sx(s) - (a >>> 1) : sx(s) + (a >>> 1);
    else    v = fi ? sx(s) + ((a + 2) >>> 2) : sx(s) - ((a + 2) >>> 2);
    return v[DW-1:0];
  endfunction

  // lifting datapath: result one cycle after its inputs are sampled
  always @(posedge clk) begin
    if (rst) bus.res_s <= '0;
    else     bus.res_s <= dp_f(bus.l_s, bus.r_s, bus.s_s, bus.e_o_s, bus.f_i_s);
  end

  function automatic int ext(input int k, input int n);
    if (k < 0) return 1;
    if (k >= n) return n - 2;
    return k;
  endfunction

  function automatic int wrap16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // whole-row reference transform on ref_x, in place; records write order
  task automatic ref_run(input bit f, input int n);
    int par, l, r, s, v;
    exp_ord.delete();
    for (int p = 0; p < 2; p++) begin
      par = (f == (p == 0)) ? 1 : 0;
      for (int i = par; i < n; i += 2) begin
        l = ref_x[ext(i - 1, n)];
        r = ref_x[ext(i + 1, n)];
        s = ref_x[i];
        if (par == 1) v = f ? s - ((l + r) >>> 1) : s + ((l + r) >>> 1);
        else          v = f ? s + ((l + r + 2) >>> 2) : s - ((l + r + 2) >>> 2);
        ref_x[i] = wrap16(v);
        exp_ord.push_back(i);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int a, input int d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d[DW-1:0];
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic load_rand(input int b, input int n);
    for (int i = 0; i <= n; i++) load_word((b + i) % RSZ, int'($urandom_range(0, 2000)) - 1000);
  endtask

  // one transform: start, bounded wait for done, timing/write/RAM checks
  task automatic run(input bit f, input int n, input int b, input int mid);
    int wr0, bz0, dc, nw, guard, exp_dc;
    for (int i = 0; i < n; i++) ref_x[i] = sx(ram[(b + i) % RSZ]);
    guard = sx(ram[(b + n) % RSZ]);
    if (n >= 2) ref_run(f, n);
    else exp_ord.delete();
    exp_dc = (n < 2) ? 1 : 6 * n + 1;
    wr0 = wr_cnt;
    bz0 = busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.fwd   = f;
    bus.len   = n[AW:0];
    bus.base  = b[AW-1:0];
    dc = -1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) bus.start = 1'b0;
      if (mid > 0 && c == mid) begin
        bus.start = 1'b1;
        bus.fwd   = ~f;
        bus.len   = 9'd2;
        bus.base  = bus.base + 8'd3;
      end
      if (mid > 0 && c == mid + 1) bus.start = 1'b0;
      if (bus.done) begin
        dc = c;
        break;
      end
    end
    bus.start = 1'b0;
    chk($sformatf("done_cycle f=%0d len=%0d", f, n), dc, exp_dc);
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(bus.done), 0);
    chk("busy_after_done", int'(bus.busy), 0);
    chk($sformatf("busy_cycles len=%0d", n), busy_cnt - bz0, (n < 2) ? 0 : 6 * n);
    nw = wr_cnt - wr0;
    chk($sformatf("write_count len=%0d", n), nw, exp_ord.size());
    for (int k = 0; k < exp_ord.size() && k < nw; k++)
      chk($sformatf("write_order[%0d]", k), int'(wr_log[(wr0 + k) % 4096]), (b + exp_ord[k]) % RSZ);
    if (n >= 2)
      for (int i = 0; i < n; i++)
        chk($sformatf("ram[%0d] base=%0d", i, b), sx(ram[(b + i) % RSZ]), ref_x[i]);
    chk("guard_untouched", sx(ram[(b + n) % RSZ]), guard);
    $display("run f=%0d len=%0d base=%0d done_cycle=%0d writes=%0d", f, n, b, dc, nw);
  endtask

  initial begin
    int wr0, hit, n, b;
    bit f;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    bus.start = 1'b0;
    bus.fwd = 1'b0;
    bus.len = '0;
    bus.base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    chk("rst_e_o_s", int'(bus.e_o_s), 0);
    chk("rst_f_i_s", int'(bus.f_i_s), 0);
    chk("rst_mem_raddr", int'(bus.mem_raddr), 0);
    chk("rst_mem_waddr", int'(bus.mem_waddr), 0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst_l_s", int'(bus.l_s), 0);
    chk("rst_r_s", int'(bus.r_s), 0);
    chk("rst_s_s", int'(bus.s_s), 0);
    rst = 1'b0;

    // forward then inverse on the reference row
    for (int i = 0; i < 4; i++) load_word(i, d1[i]);
    load_word(4, 77);
    run(1'b1, 4, 0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("fwd4_const[%0d]", i), sx(ram[i]), e1[i]);
    run(1'b0, 4, 0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("inv4_const[%0d]", i), sx(ram[i]), d1[i]);

    // odd length; guard sample at index 3 must not be used as a neighbour
    load_word(0, 8);
    load_word(1, 4);
    load_word(2, 8);
    load_word(3, 100);
    run(1'b1, 3, 0, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("fwd3_const[%0d]", i), sx(ram[i]), e3[i]);

    // address wrap-around
    for (int i = 0; i < 4; i++) load_word((254 + i) % RSZ, d1[i]);
    load_word(2, 55);
    run(1'b1, 4, 254, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_const[%0d]", i), sx(ram[(254 + i) % RSZ]), e1[i]);

    // degenerate lengths
    run(1'b1, 0, 10, 0);
    run(1'b0, 1, 10, 0);

    // reset during the second write-back
    for (int i = 0; i < 4; i++) load_word(i, d1[i]);
    wr0 = wr_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.fwd = 1'b1;
    bus.len = 9'd4;
    bus.base = 8'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.mem_we && wr_cnt == wr0 + 1) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("rst_reached_wb2", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_mem_we", int'(bus.mem_we), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_writes", wr_cnt - wr0, 2);
    chk("rst_mid_done", int'(bus.done), 0);
    $display("reset mid-run: writes=%0d", wr_cnt - wr0);

    // normal forward run afterwards, with a stray start pulse mid-run
    for (int i = 0; i < 4; i++) load_word(i, d1[i]);
    load_word(4, 77);
    run(1'b1, 4, 0, 10);
    for (int i = 0; i < 4; i++) chk($sformatf("after_rst_const[%0d]", i), sx(ram[i]), e1[i]);

    // randomized rows
    for (int t = 0; t < 8; t++) begin
      f = 1'($urandom_range(0, 1));
      n = (t == 0) ? 2 : int'($urandom_range(2, 40));
      b = (t == 1) ? 250 : int'($urandom_range(0, RSZ - 1));
      load_rand(b, n);
      run(f, n, b, (t == 2) ? 7 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
